// File: rtl/boot_copier_pkg.sv
// ============================================================================
// Module      : boot_copier_pkg
// Description : Shared types and constants for the boot ROM copier.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package boot_copier_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COPY  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BE_ALL     = 4'hF;
    localparam int         WORD_BYTES = 4;

    // Byte offset of word index idx; the caller guarantees idx fits in 30 bits.
    function automatic logic [31:0] word_offset(input logic [31:0] idx);
        return 32'(WORD_BYTES) * idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/boot_rom_copier.sv
// ============================================================================
// Module      : boot_rom_copier
// Description : Streams a word range from the boot ROM into SRAM at one word
//               per cycle and accumulates a wrapping checksum of the data.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module boot_rom_copier
    import boot_copier_pkg::*;
#(
    parameter int ROM_ADDR_WIDTH = 13,
    parameter int LEN_WIDTH      = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_WIDTH-1:0] num_words_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [31:0]          checksum_o,
    // boot ROM read port
    output logic                 rom_csn,
    output logic                 rom_wen,
    output logic [3:0]           rom_be,
    output logic [31:0]          rom_add,
    output logic [31:0]          rom_wdata,
    input  logic [31:0]          rom_rdata,
    // target SRAM write port
    output logic                 mem_csn,
    output logic                 mem_wen,
    output logic [3:0]           mem_be,
    output logic [31:0]          mem_add,
    output logic [31:0]          mem_wdata
);

    if (ROM_ADDR_WIDTH < 3 || LEN_WIDTH < 1 || LEN_WIDTH > 30) begin : g_param_check
        $error("boot_rom_copier: unsupported ROM_ADDR_WIDTH/LEN_WIDTH");
    end

    state_t               state;
    logic [31:0]          src_q;
    logic [31:0]          dst_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] rd_cnt;
    logic [LEN_WIDTH-1:0] wr_cnt;
    logic                 rd_vld;
    logic                 rom_csn_q;
    logic [31:0]          rom_add_q;
    logic [31:0]          mem_add_q;
    logic [3:0]           mem_be_q;
    logic [31:0]          wdata_hold;
    logic [31:0]          checksum_q;
    logic                 busy_q;
    logic                 done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            rd_vld     <= 1'b0;
            rom_csn_q  <= 1'b1;
            rom_add_q  <= '0;
            mem_add_q  <= '0;
            mem_be_q   <= '0;
            wdata_hold <= '0;
            checksum_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // The ROM answers one cycle after the read, so the write follows it.
            rd_vld <= ~rom_csn_q;

            if (rd_vld) begin
                wr_cnt     <= wr_cnt + LEN_WIDTH'(1);
                checksum_q <= checksum_q + rom_rdata;
                wdata_hold <= rom_rdata;
            end

            // Address for the write that retires next cycle's returned word.
            if (!rom_csn_q) begin
                mem_add_q <= dst_q + word_offset(32'(wr_cnt + LEN_WIDTH'(rd_vld)));
                mem_be_q  <= BE_ALL;
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        src_q      <= {src_addr_i[31:2], 2'b00};
                        dst_q      <= {dst_addr_i[31:2], 2'b00};
                        len_q      <= num_words_i;
                        rd_cnt     <= '0;
                        wr_cnt     <= '0;
                        checksum_q <= '0;
                        busy_q     <= 1'b1;
                        if (num_words_i == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= S_COPY;
                            rom_csn_q <= 1'b0;
                            rom_add_q <= {src_addr_i[31:2], 2'b00};
                        end
                    end
                end
                S_COPY: begin
                    if (rd_cnt == len_q - LEN_WIDTH'(1)) begin
                        rom_csn_q <= 1'b1;
                        state     <= S_DRAIN;
                    end else begin
                        rd_cnt    <= rd_cnt + LEN_WIDTH'(1);
                        rom_add_q <= src_q + word_offset(32'(rd_cnt + LEN_WIDTH'(1)));
                    end
                end
                S_DRAIN: begin
                    state  <= S_DONE;
                    done_q <= 1'b1;
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign checksum_o = checksum_q;

    assign rom_csn    = rom_csn_q;
    assign rom_wen    = 1'b1;
    assign rom_be     = 4'h0;
    assign rom_add    = rom_add_q;
    assign rom_wdata  = 32'h0;

    // Write data passes straight through from the ROM; it holds while idle.
    assign mem_csn    = ~rd_vld;
    assign mem_wen    = ~rd_vld;
    assign mem_be     = mem_be_q;
    assign mem_add    = mem_add_q;
    assign mem_wdata  = rd_vld ? rom_rdata : wdata_hold;

endmodule

`default_nettype wire

// File: tb/tb_boot_rom_copier.sv
// ============================================================================
// Module      : tb_boot_rom_copier
// Description : Directed self-checking bench for boot_rom_copier.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_boot_rom_copier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [11:0] num;
    logic        busy, done;
    logic [31:0] checksum;
    logic        rom_csn, rom_wen;
    logic [3:0]  rom_be;
    logic [31:0] rom_add, rom_wdata, rom_rdata;
    logic        mem_csn, mem_wen;
    logic [3:0]  mem_be;
    logic [31:0] mem_add, mem_wdata;

    logic [31:0] rom_mem [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    logic        lg_rom_csn [0:31];
    logic [31:0] lg_rom_add [0:31];
    logic        lg_mem_csn [0:31];
    logic        lg_mem_wen [0:31];
    logic [3:0]  lg_mem_be  [0:31];
    logic [31:0] lg_mem_add [0:31];
    logic [31:0] lg_mem_dat [0:31];
    logic        lg_done    [0:31];
    logic        lg_busy    [0:31];
    logic [31:0] lg_sum     [0:31];

    boot_rom_copier #(.ROM_ADDR_WIDTH(13), .LEN_WIDTH(12)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .src_addr_i (src),
        .dst_addr_i (dst),
        .num_words_i(num),
        .busy_o     (busy),
        .done_o     (done),
        .checksum_o (checksum),
        .rom_csn    (rom_csn),
        .rom_wen    (rom_wen),
        .rom_be     (rom_be),
        .rom_add    (rom_add),
        .rom_wdata  (rom_wdata),
        .rom_rdata  (rom_rdata),
        .mem_csn    (mem_csn),
        .mem_wen    (mem_wen),
        .mem_be     (mem_be),
        .mem_add    (mem_add),
        .mem_wdata  (mem_wdata)
    );

    always #5 clk = ~clk;

    // 8 KiB ROM with 1-cycle read latency; only add[12:2] is decoded.
    always @(posedge clk) begin
        if (!rom_csn && rom_wen) rom_rdata <= rom_mem[rom_add[12:2]];
    end

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [11:0] n);
        @(negedge clk);
        start = 1'b1; src = s; dst = d; num = n;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Records cycles 1..m after the start edge; optionally pulses start in cycles pa/pb.
    task automatic capture(input int m, input int pa, input int pb);
        for (int c = 1; c <= m; c++) begin
            @(negedge clk);
            lg_rom_csn[c] = rom_csn;  lg_rom_add[c] = rom_add;
            lg_mem_csn[c] = mem_csn;  lg_mem_wen[c] = mem_wen;
            lg_mem_be[c]  = mem_be;   lg_mem_add[c] = mem_add;
            lg_mem_dat[c] = mem_wdata;
            lg_done[c]    = done;     lg_busy[c]    = busy;
            lg_sum[c]     = checksum;
            if (c == pa || c == pb) begin
                start = 1'b1; src = 32'h100; dst = 32'h2000_0000; num = 12'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({busy, done, checksum} !== 34'h0) begin
            n_bad++; $display("FAIL reset_status got busy=%b done=%b sum=%h want 0/0/0", busy, done, checksum);
        end
        n_cmp++;
        if ({rom_csn, rom_wen, rom_be, rom_add, rom_wdata} !== {1'b1, 1'b1, 4'h0, 64'h0}) begin
            n_bad++; $display("FAIL reset_rom_port got csn=%b wen=%b be=%h add=%h", rom_csn, rom_wen, rom_be, rom_add);
        end
        n_cmp++;
        if ({mem_csn, mem_wen, mem_be, mem_add, mem_wdata} !== {1'b1, 1'b1, 4'h0, 64'h0}) begin
            n_bad++; $display("FAIL reset_mem_port got csn=%b wen=%b be=%h add=%h wdata=%h", mem_csn, mem_wen, mem_be, mem_add, mem_wdata);
        end
    endtask

    task automatic test_basic_copy();
        start_copy(32'h0, 32'h1C00_0000, 12'd4);
        capture(7, 0, 0);
        for (int c = 1; c <= 7; c++) begin
            n_cmp++;
            if (lg_rom_csn[c] !== !(c <= 4) || (c <= 4 && lg_rom_add[c] !== 32'(4 * (c - 1)))) begin
                n_bad++; $display("FAIL basic_read c%0d got csn=%b add=%h want csn=%b add=%h", c, lg_rom_csn[c], lg_rom_add[c], !(c <= 4), 32'(4 * (c - 1)));
            end
            n_cmp++;
            if (lg_mem_csn[c] !== !(c >= 2 && c <= 5)) begin
                n_bad++; $display("FAIL basic_mem_csn c%0d got %b want %b", c, lg_mem_csn[c], !(c >= 2 && c <= 5));
            end
            if (c >= 2 && c <= 5) begin
                n_cmp++;
                if (lg_mem_wen[c] !== 1'b0 || lg_mem_be[c] !== 4'hF ||
                    lg_mem_add[c] !== 32'h1C00_0000 + 32'(4 * (c - 2)) ||
                    lg_mem_dat[c] !== 32'(32'h1111_1111 * (c - 1))) begin
                    n_bad++; $display("FAIL basic_write c%0d got wen=%b be=%h add=%h data=%h want 0/f/%h/%h", c, lg_mem_wen[c], lg_mem_be[c], lg_mem_add[c], lg_mem_dat[c], 32'h1C00_0000 + 32'(4 * (c - 2)), 32'(32'h1111_1111 * (c - 1)));
                end
            end
            n_cmp++;
            if (lg_done[c] !== (c == 6) || lg_busy[c] !== (c <= 6)) begin
                n_bad++; $display("FAIL basic_status c%0d got done=%b busy=%b want %b/%b", c, lg_done[c], lg_busy[c], c == 6, c <= 6);
            end
        end
        n_cmp++;
        if (lg_sum[6] !== 32'hAAAA_AAAA) begin
            n_bad++; $display("FAIL basic_checksum got %h want aaaaaaaa", lg_sum[6]);
        end
    endtask

    task automatic test_zero_len();
        start_copy(32'h40, 32'h1C00_0000, 12'd0);
        capture(3, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if (lg_rom_csn[c] !== 1'b1 || lg_mem_csn[c] !== 1'b1 ||
                lg_done[c] !== (c == 1) || lg_busy[c] !== (c == 1)) begin
                n_bad++; $display("FAIL zero_len c%0d got rcsn=%b mcsn=%b done=%b busy=%b", c, lg_rom_csn[c], lg_mem_csn[c], lg_done[c], lg_busy[c]);
            end
        end
        n_cmp++;
        if (lg_sum[1] !== 32'h0) begin
            n_bad++; $display("FAIL zero_len_checksum got %h want 0", lg_sum[1]);
        end
    endtask

    task automatic test_start_ignored();
        int writes = 0;
        int dones  = 0;
        logic [31:0] exp_d;
        start_copy(32'h0, 32'h1C00_0040, 12'd8);
        capture(14, 3, 10);
        for (int c = 1; c <= 14; c++) begin
            if (lg_mem_csn[c] === 1'b0 && lg_mem_wen[c] === 1'b0) writes++;
            if (lg_done[c] === 1'b1) dones++;
        end
        n_cmp++;
        if (writes != 8) begin
            n_bad++; $display("FAIL ignore_write_count got %0d want 8", writes);
        end
        n_cmp++;
        if (dones != 1 || lg_done[10] !== 1'b1 || lg_busy[12] !== 1'b0) begin
            n_bad++; $display("FAIL ignore_done got count=%0d done10=%b busy12=%b want 1/1/0", dones, lg_done[10], lg_busy[12]);
        end
        for (int c = 2; c <= 9; c++) begin
            exp_d = (c <= 5) ? 32'(32'h1111_1111 * (c - 1)) : (32'h5A00_0000 | 32'(c - 2));
            n_cmp++;
            if (lg_mem_add[c] !== 32'h1C00_0040 + 32'(4 * (c - 2)) || lg_mem_dat[c] !== exp_d) begin
                n_bad++; $display("FAIL ignore_write c%0d got add=%h data=%h want %h/%h", c, lg_mem_add[c], lg_mem_dat[c], 32'h1C00_0040 + 32'(4 * (c - 2)), exp_d);
            end
        end
        n_cmp++;
        if (lg_sum[10] !== 32'h12AA_AAC0) begin
            n_bad++; $display("FAIL ignore_checksum got %h want 12aaaac0", lg_sum[10]);
        end
    endtask

    task automatic test_alias();
        logic [31:0] exp_a [4];
        logic [31:0] exp_d [4];
        exp_a = '{32'h1FF8, 32'h1FFC, 32'h2000, 32'h2004};
        exp_d = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1111_1111, 32'h2222_2222};
        start_copy(32'h1FF8, 32'h1C00_0000, 12'd4);
        capture(7, 0, 0);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (lg_rom_csn[k + 1] !== 1'b0 || lg_rom_add[k + 1] !== exp_a[k]) begin
                n_bad++; $display("FAIL alias_read k%0d got csn=%b add=%h want 0/%h", k, lg_rom_csn[k + 1], lg_rom_add[k + 1], exp_a[k]);
            end
            n_cmp++;
            if (lg_mem_csn[k + 2] !== 1'b0 || lg_mem_dat[k + 2] !== exp_d[k]) begin
                n_bad++; $display("FAIL alias_write k%0d got csn=%b data=%h want 0/%h", k, lg_mem_csn[k + 2], lg_mem_dat[k + 2], exp_d[k]);
            end
        end
        n_cmp++;
        if (lg_sum[6] !== 32'hDCDF_E22F || lg_done[6] !== 1'b1) begin
            n_bad++; $display("FAIL alias_checksum got sum=%h done=%b want dcdfe22f/1", lg_sum[6], lg_done[6]);
        end
    endtask

    task automatic test_reset_mid_copy();
        start_copy(32'h0, 32'h1C00_0000, 12'd16);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rom_csn !== 1'b1 || mem_csn !== 1'b1 || busy !== 1'b0 || checksum !== 32'h0) begin
            n_bad++; $display("FAIL midreset got rcsn=%b mcsn=%b busy=%b sum=%h want 1/1/0/0", rom_csn, mem_csn, busy, checksum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture(6, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            n_cmp++;
            if (lg_done[c] !== 1'b0 || lg_busy[c] !== 1'b0 || lg_rom_csn[c] !== 1'b1 || lg_mem_csn[c] !== 1'b1) begin
                n_bad++; $display("FAIL midreset_quiet c%0d got done=%b busy=%b rcsn=%b mcsn=%b", c, lg_done[c], lg_busy[c], lg_rom_csn[c], lg_mem_csn[c]);
            end
        end
        start_copy(32'h8, 32'h1C00_0100, 12'd1);
        capture(4, 0, 0);
        n_cmp++;
        if (lg_rom_csn[1] !== 1'b0 || lg_rom_add[1] !== 32'h8) begin
            n_bad++; $display("FAIL restart_read got csn=%b add=%h want 0/00000008", lg_rom_csn[1], lg_rom_add[1]);
        end
        n_cmp++;
        if (lg_mem_csn[2] !== 1'b0 || lg_mem_add[2] !== 32'h1C00_0100 || lg_mem_dat[2] !== 32'h3333_3333) begin
            n_bad++; $display("FAIL restart_write got csn=%b add=%h data=%h want 0/1c000100/33333333", lg_mem_csn[2], lg_mem_add[2], lg_mem_dat[2]);
        end
        n_cmp++;
        if (lg_done[3] !== 1'b1 || lg_sum[3] !== 32'h3333_3333 || lg_busy[4] !== 1'b0 || lg_sum[4] !== 32'h3333_3333) begin
            n_bad++; $display("FAIL restart_done got done3=%b sum3=%h busy4=%b sum4=%h", lg_done[3], lg_sum[3], lg_busy[4], lg_sum[4]);
        end
    endtask

    task automatic test_misaligned();
        start_copy(32'h6, 32'h1C00_0003, 12'd1);
        capture(3, 0, 0);
        n_cmp++;
        if (lg_rom_csn[1] !== 1'b0 || lg_rom_add[1] !== 32'h4) begin
            n_bad++; $display("FAIL misaligned_read got csn=%b add=%h want 0/00000004", lg_rom_csn[1], lg_rom_add[1]);
        end
        n_cmp++;
        if (lg_mem_csn[2] !== 1'b0 || lg_mem_add[2] !== 32'h1C00_0000 || lg_mem_dat[2] !== 32'h2222_2222) begin
            n_bad++; $display("FAIL misaligned_write got csn=%b add=%h data=%h want 0/1c000000/22222222", lg_mem_csn[2], lg_mem_add[2], lg_mem_dat[2]);
        end
        n_cmp++;
        if (lg_done[3] !== 1'b1 || lg_sum[3] !== 32'h2222_2222) begin
            n_bad++; $display("FAIL misaligned_done got done=%b sum=%h want 1/22222222", lg_done[3], lg_sum[3]);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 32'h5A00_0000 | 32'(i);
        rom_mem[0]     = 32'h1111_1111;
        rom_mem[1]     = 32'h2222_2222;
        rom_mem[2]     = 32'h3333_3333;
        rom_mem[3]     = 32'h4444_4444;
        rom_mem[2046]  = 32'hDEAD_BEEF;
        rom_mem[2047]  = 32'hCAFE_F00D;
        rom_rdata = 32'h0;
        rst_n = 1'b0;
        start = 1'b0;
        src   = 32'h0;
        dst   = 32'h0;
        num   = 12'd0;
        repeat (3) @(posedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic_copy();
        test_zero_len();
        test_start_ignored();
        test_alias();
        test_reset_mid_copy();
        test_misaligned();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
